// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the single register-file write port between two writeback
// requesters: port 0 (ALU) and port 1 (load unit). Each requester pushes
// {rd, data} into its own small FIFO through a valid/ready handshake. A
// round-robin arbiter pops at most one FIFO head per cycle into a registered
// write stage, and that stage drives register_file directly.
//
// Parameters:
//   XLEN       data width of write_data
//   RA_W       register address width
//   FIFO_DEPTH entries per requester FIFO (power of 2, >= 2)
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   req0_valid/ready/rd/data     ALU writeback request channel
//   req1_valid/ready/rd/data     load-unit writeback request channel
//   wb_stall                     freezes arbitration and the write stage
//   reg_write, rd, write_data    register_file write port (registered)
//   idle                         both FIFOs empty and no write in the stage
//
// Optional feature (macro WB_HAZARD_EN):
//   chk_rs1, chk_rs2             source registers to look up
//   rs1_pending, rs2_pending     combinational: the register has a write
//                                still queued or in the write stage
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int RA_W       = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [RA_W-1:0] req0_rd,
  input  logic [XLEN-1:0] req0_data,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [RA_W-1:0] req1_rd,
  input  logic [XLEN-1:0] req1_data,
  input  logic            wb_stall,
  output logic            reg_write,
  output logic [RA_W-1:0] rd,
  output logic [XLEN-1:0] write_data,
  output logic            idle
`ifdef WB_HAZARD_EN
  ,
  input  logic [RA_W-1:0] chk_rs1,
  input  logic [RA_W-1:0] chk_rs2,
  output logic            rs1_pending,
  output logic            rs2_pending
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  // Per-port views, indexed by requester number.
  logic [1:0]      in_valid;
  logic [RA_W-1:0] in_rd     [2];
  logic [XLEN-1:0] in_data   [2];
  logic [1:0]      push;
  logic [1:0]      pop;
  logic [1:0]      empty;
  logic [1:0]      full;
  logic [CW-1:0]   count     [2];
  logic [RA_W-1:0] head_rd   [2];
  logic [XLEN-1:0] head_data [2];

`ifdef WB_HAZARD_EN
  logic            hit1 [2][FIFO_DEPTH];
  logic            hit2 [2][FIFO_DEPTH];
`endif

  assign in_valid   = {req1_valid, req0_valid};
  assign in_rd[0]   = req0_rd;
  assign in_rd[1]   = req1_rd;
  assign in_data[0] = req0_data;
  assign in_data[1] = req1_data;

  // Ready depends on the count only: a full FIFO refuses a push even when
  // its head is being popped in the same cycle, which keeps ready free of
  // any path through the arbiter.
  assign req0_ready = ~full[0];
  assign req1_ready = ~full[1];

  // -------------------------------------------------------------------------
  // Requester FIFOs
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      logic [RA_W-1:0] mem_rd   [FIFO_DEPTH];
      logic [XLEN-1:0] mem_data [FIFO_DEPTH];
      logic [PW-1:0]   wptr_reg;
      logic [PW-1:0]   rptr_reg;
      logic [CW-1:0]   count_reg;

      assign full[gi]      = (count_reg == FULL_CNT);
      assign empty[gi]     = (count_reg == '0);
      assign push[gi]      = in_valid[gi] & ~full[gi];
      assign count[gi]     = count_reg;
      assign head_rd[gi]   = mem_rd[rptr_reg];
      assign head_data[gi] = mem_data[rptr_reg];

      // Storage needs no reset: occupancy is tracked by the pointers.
      always_ff @(posedge clk) begin
        if (push[gi]) begin
          mem_rd[wptr_reg]   <= in_rd[gi];
          mem_data[wptr_reg] <= in_data[gi];
        end
      end

      // Pointers wrap naturally because FIFO_DEPTH is a power of 2.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wptr_reg  <= '0;
          rptr_reg  <= '0;
          count_reg <= '0;
        end else begin
          if (push[gi]) wptr_reg <= wptr_reg + PW'(1);
          if (pop[gi])  rptr_reg <= rptr_reg + PW'(1);
          count_reg <= count_reg + CW'(push[gi]) - CW'(pop[gi]);
        end
      end

`ifdef WB_HAZARD_EN
      // An entry slot is live when its distance from the read pointer is
      // below the current count.
      for (genvar gj = 0; gj < FIFO_DEPTH; gj++) begin : g_entry
        logic [PW-1:0] offs;
        logic          live;
        assign offs           = PW'(gj) - rptr_reg;
        assign live           = ({1'b0, offs} < count_reg);
        assign hit1[gi][gj]   = live && (mem_rd[gj] == chk_rs1);
        assign hit2[gi][gj]   = live && (mem_rd[gj] == chk_rs2);
      end
`else
      // Without hazard lookup only the FIFO head is ever observed.
`endif
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Round-robin arbiter
  // -------------------------------------------------------------------------
  logic            rr_reg;
  logic            rr_next;
  logic            win;
  logic            any_pop;
  logic [RA_W-1:0] sel_rd;
  logic [XLEN-1:0] sel_data;

  always_comb begin
    pop      = 2'b00;
    rr_next  = rr_reg;
    win      = 1'b0;
    any_pop  = 1'b0;
    // With both candidates the pointer chooses; with one, the non-empty
    // port is taken. Either way the pointer then favours the loser, which
    // for the two-candidate case is simply a flip.
    if (!empty[0] && !empty[1]) begin
      win = rr_reg;
    end else begin
      win = empty[0];
    end
    if (!wb_stall && !(empty[0] && empty[1])) begin
      any_pop  = 1'b1;
      pop[win] = 1'b1;
      rr_next  = ~win;
    end
    sel_rd   = head_rd[win];
    sel_data = head_data[win];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_reg <= 1'b0;
    end else begin
      rr_reg <= rr_next;
    end
  end

  // -------------------------------------------------------------------------
  // Write stage
  // -------------------------------------------------------------------------
  // An rd==0 entry is consumed and loaded like any other, but it never
  // raises reg_write since x0 is hard-wired in register_file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write  <= 1'b0;
      rd         <= '0;
      write_data <= '0;
    end else if (any_pop) begin
      reg_write  <= (sel_rd != '0);
      rd         <= sel_rd;
      write_data <= sel_data;
    end else begin
      reg_write  <= 1'b0;
    end
  end

  assign idle = (count[0] == '0) && (count[1] == '0) && !reg_write;

  // -------------------------------------------------------------------------
  // Pending-write lookup
  // -------------------------------------------------------------------------
`ifdef WB_HAZARD_EN
  always_comb begin
    rs1_pending = reg_write && (rd == chk_rs1);
    rs2_pending = reg_write && (rd == chk_rs2);
    for (int p = 0; p < 2; p++) begin
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        rs1_pending = rs1_pending | hit1[p][e];
        rs2_pending = rs2_pending | hit2[p][e];
      end
    end
    // x0 never becomes stale.
    if (chk_rs1 == '0) rs1_pending = 1'b0;
    if (chk_rs2 == '0) rs2_pending = 1'b0;
  end
`else
  // No pending-write lookup in this build.
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid;
  logic        req0_ready;
  logic [4:0]  req0_rd;
  logic [31:0] req0_data;
  logic        req1_valid;
  logic        req1_ready;
  logic [4:0]  req1_rd;
  logic [31:0] req1_data;
  logic        wb_stall;
  logic        reg_write;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic        idle;
`ifdef WB_HAZARD_EN
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic        rs1_pending;
  logic        rs2_pending;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  regfile_wb_arbiter #(.XLEN(32), .RA_W(5), .FIFO_DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_rd    (req0_rd),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_rd    (req1_rd),
    .req1_data  (req1_data),
    .wb_stall   (wb_stall),
    .reg_write  (reg_write),
    .rd         (rd),
    .write_data (write_data),
    .idle       (idle)
`ifdef WB_HAZARD_EN
    ,
    .chk_rs1    (chk_rs1),
    .chk_rs2    (chk_rs2),
    .rs1_pending(rs1_pending),
    .rs2_pending(rs2_pending)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic [4:0]  rd0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  rd1;
    logic [31:0] d1;
    logic        stall;
    logic        e_rw;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    logic        e_idle;
    logic        e_rdy0;
    logic        e_rdy1;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic rw, input logic [4:0] erd,
                               input logic [31:0] ewd, input logic eidle,
                               input logic r0, input logic r1);
    check({tag, ".reg_write"}, 32'(reg_write), 32'(rw));
    check({tag, ".rd"}, 32'(rd), 32'(erd));
    check({tag, ".write_data"}, write_data, ewd);
    check({tag, ".idle"}, 32'(idle), 32'(eidle));
    check({tag, ".req0_ready"}, 32'(req0_ready), 32'(r0));
    check({tag, ".req1_ready"}, 32'(req1_ready), 32'(r1));
  endtask

  function automatic vec_t mk(input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                              input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
                              input logic stall, input logic rw, input logic [4:0] erd,
                              input logic [31:0] ewd, input logic eidle,
                              input logic r0, input logic r1);
    vec_t v;
    v.v0 = v0; v.rd0 = rd0; v.d0 = d0;
    v.v1 = v1; v.rd1 = rd1; v.d1 = d1;
    v.stall = stall; v.e_rw = rw; v.e_rd = erd; v.e_wd = ewd;
    v.e_idle = eidle; v.e_rdy0 = r0; v.e_rdy1 = r1;
    return v;
  endfunction

  // Scoreboard state for the contention sequence.
  int   n0, n1, w0, w1;
  logic nextp;
  logic a0, a1;

  task automatic check_write();
    if (rd == 5'd12) begin
      check($sformatf("alt.p0_data[%0d]", w0), write_data, 32'(100 + w0));
      w0++;
    end else begin
      check($sformatf("alt.p1_rd[%0d]", w1), 32'(rd), 32'd8);
      check($sformatf("alt.p1_data[%0d]", w1), write_data, 32'(7 + w1));
      w1++;
    end
  endtask

  initial begin
    // One vector per cycle: inputs held across the edge, outputs checked
    // just after it.
    //            v0 rd0   d0      v1 rd1   d1         st rw rd    wd        idle r0 r1
    vecs[0]  = mk(1, 5'd15, 32'd42, 0, 5'd0, 32'd0,      0, 0, 5'd0,  32'd0,      0, 1, 1);
    vecs[1]  = mk(0, 5'd0,  32'd0,  0, 5'd0, 32'd0,      0, 1, 5'd15, 32'd42,     0, 1, 1);
    vecs[2]  = mk(0, 5'd0,  32'd0,  0, 5'd0, 32'd0,      0, 0, 5'd15, 32'd42,     1, 1, 1);
    // x0 entry consumed silently, then rd=6 written normally
    vecs[3]  = mk(0, 5'd0,  32'd0,  1, 5'd0, 32'hDEAD,   0, 0, 5'd15, 32'd42,     0, 1, 1);
    vecs[4]  = mk(0, 5'd0,  32'd0,  1, 5'd6, 32'h66,     0, 0, 5'd0,  32'hDEAD,   0, 1, 1);
    vecs[5]  = mk(0, 5'd0,  32'd0,  0, 5'd0, 32'd0,      0, 1, 5'd6,  32'h66,     0, 1, 1);
    vecs[6]  = mk(0, 5'd0,  32'd0,  0, 5'd0, 32'd0,      0, 0, 5'd6,  32'h66,     1, 1, 1);
    // stall four cycles while port 0 offers rd=3,4,5
    vecs[7]  = mk(1, 5'd3,  32'd30, 0, 5'd0, 32'd0,      1, 0, 5'd6,  32'h66,     0, 1, 1);
    vecs[8]  = mk(1, 5'd4,  32'd40, 0, 5'd0, 32'd0,      1, 0, 5'd6,  32'h66,     0, 0, 1);
    vecs[9]  = mk(1, 5'd5,  32'd50, 0, 5'd0, 32'd0,      1, 0, 5'd6,  32'h66,     0, 0, 1);
    vecs[10] = mk(1, 5'd5,  32'd50, 0, 5'd0, 32'd0,      1, 0, 5'd6,  32'h66,     0, 0, 1);
    vecs[11] = mk(1, 5'd5,  32'd50, 0, 5'd0, 32'd0,      0, 1, 5'd3,  32'd30,     0, 1, 1);
    vecs[12] = mk(1, 5'd5,  32'd50, 0, 5'd0, 32'd0,      0, 1, 5'd4,  32'd40,     0, 1, 1);
    vecs[13] = mk(0, 5'd0,  32'd0,  0, 5'd0, 32'd0,      0, 1, 5'd5,  32'd50,     0, 1, 1);
    vecs[14] = mk(0, 5'd0,  32'd0,  0, 5'd0, 32'd0,      0, 0, 5'd5,  32'd50,     1, 1, 1);

    rst_n = 1'b0;
    req0_valid = 1'b0; req0_rd = '0; req0_data = '0;
    req1_valid = 1'b0; req1_rd = '0; req1_data = '0;
    wb_stall = 1'b0;
`ifdef WB_HAZARD_EN
    chk_rs1 = 5'd9;
    chk_rs2 = 5'd0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs("reset", 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1);
`ifdef WB_HAZARD_EN
    check("reset.rs1_pending", 32'(rs1_pending), 32'd0);
`endif

    for (int i = 0; i < NV; i++) begin
      req0_valid = vecs[i].v0; req0_rd = vecs[i].rd0; req0_data = vecs[i].d0;
      req1_valid = vecs[i].v1; req1_rd = vecs[i].rd1; req1_data = vecs[i].d1;
      wb_stall   = vecs[i].stall;
      tick();
      check_outputs($sformatf("vec%0d", i), vecs[i].e_rw, vecs[i].e_rd, vecs[i].e_wd,
                    vecs[i].e_idle, vecs[i].e_rdy0, vecs[i].e_rdy1);
    end

    // Reset pulse so the round-robin pointer starts at port 0.
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Both requesters push every cycle: writes must alternate port 0 / 1.
    n0 = 0; n1 = 0; w0 = 0; w1 = 0; nextp = 1'b0;
    for (int c = 0; c < 24; c++) begin
      req0_valid = 1'b1; req0_rd = 5'd12; req0_data = 32'(100 + n0);
      req1_valid = 1'b1; req1_rd = 5'd8;  req1_data = 32'(7 + n1);
      a0 = req0_ready;
      a1 = req1_ready;
      tick();
      if (a0) n0++;
      if (a1) n1++;
      if (reg_write) begin
        check($sformatf("alt.port[%0d]", w0 + w1), (rd == 5'd12) ? 32'd0 : 32'd1, 32'(nextp));
        nextp = ~nextp;
        check_write();
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (reg_write) check_write();
    end
    check("alt.p0_count", 32'(w0), 32'(n0));
    check("alt.p1_count", 32'(w1), 32'(n1));
    check("alt.idle", 32'(idle), 32'd1);
    check("alt.min_writes", 32'(w0 + w1 >= 20), 32'd1);

    // Mid-traffic reset with three entries queued and a write in flight.
    wb_stall = 1'b1;
    req0_valid = 1'b1; req0_rd = 5'd9;  req0_data = 32'd1;
    req1_valid = 1'b1; req1_rd = 5'd10; req1_data = 32'd2;
    tick();
    req0_data = 32'd3;
    req1_valid = 1'b0;
    tick();
    req0_valid = 1'b0;
    check("rst.idle_busy", 32'(idle), 32'd0);
    check("rst.req0_full", 32'(req0_ready), 32'd0);
`ifdef WB_HAZARD_EN
    check("haz.rs1_pending", 32'(rs1_pending), 32'd1);
    check("haz.rs2_pending", 32'(rs2_pending), 32'd0);
`endif
    wb_stall = 1'b0;
    tick();
    check("rst.in_flight", 32'(reg_write), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst.async_reg_write", 32'(reg_write), 32'd0);
    check("rst.async_rd", 32'(rd), 32'd0);
    check("rst.async_write_data", write_data, 32'd0);
    check("rst.async_idle", 32'(idle), 32'd1);
`ifdef WB_HAZARD_EN
    check("haz.after_reset", 32'(rs1_pending), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("rst.no_write[%0d]", c), 32'(reg_write), 32'd0);
      check($sformatf("rst.idle[%0d]", c), 32'(idle), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port (reg_write/rd/write_data) between two writeback requesters: port 0 (ALU) and port 1 (load unit). Each requester pushes into its own 2-entry FIFO through a valid/ready handshake. A round-robin arbiter pops at most one entry per cycle into a registered write stage that drives register_file directly. Sits between the execute/memory stages and register_file.

Parameters:
XLEN, 32, data width of write_data
RA_W, 5, register address width
FIFO_DEPTH, 2, entries per requester FIFO (power of 2, >=2)

Ports:
clk  in  1  rising-edge clock shared with register_file
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  ALU writeback request
req0_ready  out  1  ALU FIFO not full
req0_rd  in  RA_W  ALU destination register
req0_data  in  XLEN  ALU result
req1_valid  in  1  load writeback request
req1_ready  out  1  load FIFO not full
req1_rd  in  RA_W  load destination register
req1_data  in  XLEN  load data
wb_stall  in  1  freezes arbitration and the write stage
reg_write  out  1  write enable to register_file
rd  out  RA_W  write address to register_file
write_data  out  XLEN  write data to register_file
idle  out  1  both FIFOs empty and no write in the stage

Behaviour:
- Reset (async, rst_n=0): FIFOs emptied, pointers/counts=0, RR pointer=port 0, reg_write=0, rd=0, write_data=0, idle=1, reqN_ready=1 once rst_n deasserts.
- Push: reqN_valid & reqN_ready at posedge writes {rd,data} at tail. reqN_ready = !full, from count only; no push into a full FIFO even if a pop happens that same cycle.
- Arbitration (wb_stall=0): candidates = non-empty FIFOs. One candidate -> it wins. Both -> port named by the RR pointer wins; pointer then flips to the other port. With a single candidate, the pointer moves to the port that did not win.
- Pop: the winner's head is popped and loaded into the write stage. reg_write=1 the next cycle. Latency: push at edge N -> reg_write high in cycle N+1 at the earliest (empty FIFO, no contention), so register_file writes at edge N+2.
- No candidate: reg_write=0 next cycle; rd/write_data hold their last values.
- x0 suppression: an entry with rd==0 is popped normally, but reg_write stays 0 for that cycle. rd/write_data still load.
- wb_stall=1: no pop, RR pointer holds, reg_write forced 0 next cycle; pushes continue until the FIFOs are full.
- Simultaneous push and pop on the same non-full FIFO: both occur; count unchanged.
- Same rd in both FIFOs: writes are issued in arbitration order. The later write wins in register_file, and no merging is done.
- FIFO pointers wrap modulo FIFO_DEPTH; count is RA-independent, width clog2(FIFO_DEPTH)+1.
- idle = both counts 0 & reg_write=0.
- Reset asserted mid-operation: queued entries are dropped, and any in-flight write is cancelled (reg_write->0 immediately).

Optional Feature:
Macro WB_HAZARD_EN.
- Defined: adds inputs chk_rs1, chk_rs2 (RA_W) and outputs rs1_pending, rs2_pending (1 bit each, combinational).
- rsN_pending=1 iff chk_rsN!=0 and it matches the rd of any valid entry in either FIFO, or the write stage with reg_write=1.
- Lets the sequencer stall reads of stale registers.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset with both FIFOs idle -> reg_write=0, rd=0, write_data=0, idle=1, req0_ready=req1_ready=1.
- Single push req0 rd=15 data=42 at edge 1 -> reg_write=1, rd=15, write_data=42 in cycle 2; idle returns to 1 in cycle 3.
- Both requesters push every cycle: req0 rd=12 data=100.., req1 rd=8 data=7.. -> writes alternate port0, port1, port0, ... with one write per cycle; no entry lost or duplicated.
- wb_stall=1 for 4 cycles while req0 pushes rd=3,4,5 -> req0_ready drops after 2 accepted; reg_write=0 throughout. Deassert stall -> rd=3 then rd=4 written, then rd=5 accepted and written.
- Push req1 rd=0 data=0xDEAD -> entry consumed, reg_write stays 0; a following req1 rd=6 writes normally.
- rst_n pulsed low mid-traffic with 3 entries queued -> outputs return to reset values asynchronously and no further writes occur. With WB_HAZARD_EN: queued rd=9 and chk_rs1=9 -> rs1_pending=1; chk_rs2=0 -> rs2_pending=0.
